ones_pattern_gen: RTL

//  Inverse of the team's 15-input ones counter: accepts a 4-bit count N over a

---
 rtl/ones_pattern_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ones_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ones_pattern_gen
//  Purpose  : Regenerates a FRAME_LEN-bit thermometer pattern (ones first)
//             holding exactly N ones. N arrives over a valid/ready handshake.
//             The pattern is streamed serially, one bit per clock, and then
//             presented in parallel with a one-cycle par_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module ones_pattern_gen #(
    parameter int FRAME_LEN = 15,   // bits per frame, 2..15
    parameter int CNT_W     = 4     // width of in_count, 2**CNT_W > FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [CNT_W-1:0]     in_count,
    output logic                 in_ready,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic [FRAME_LEN-1:0] par_out,
    output logic                 par_valid,
    output logic                 err_sat
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] c_last_idx  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_idx;          // index of the bit currently on ser_out
    logic [CNT_W-1:0]       r_count;        // saturated ones count for this frame
    logic                   r_ser_out;
    logic                   r_ser_valid;
    logic                   r_frame_start;
    logic                   r_frame_end;
    logic [FRAME_LEN-1:0]   r_par_out;
    logic                   r_par_valid;
    logic                   r_err_sat;

    logic                   w_accept;
    logic                   w_req_over;
    logic [CNT_W-1:0]       w_req_sat;
    logic [CNT_W-1:0]       w_idx_next;
    logic                   w_last_bit;
    logic [FRAME_LEN-1:0]   w_therm;

    // ------------------------------------------------------------------------
    // Handshake and request saturation
    // ------------------------------------------------------------------------
    // Ready depends only on state and reset so that no combinational path
    // exists from in_valid back to in_ready.
    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;

    // Requests larger than the frame are clamped to an all-ones frame.
    assign w_req_over = (in_count > c_frame_len);
    assign w_req_sat  = w_req_over ? c_frame_len : in_count;

    // Bit-index bookkeeping. The index never wraps: the frame ends when the
    // last position is on the output.
    assign w_idx_next = r_idx + c_one;
    assign w_last_bit = (r_idx == c_last_idx);

    // ------------------------------------------------------------------------
    // Thermometer decode of the latched count: bit i set when i < N
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_therm
            assign w_therm[gi] = (CNT_W'(gi) < r_count);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // Bit 0 of a frame is loaded on the accepting edge so it is visible in the
    // very next cycle; each following SHIFT edge loads the next bit. The DONE
    // cycle publishes the parallel pattern and gives a one-cycle gap before
    // the block is ready again (frame period FRAME_LEN+2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_count       <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_par_out     <= '0;
            r_par_valid   <= 1'b0;
            r_err_sat     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_par_valid <= 1'b0;
            r_err_sat   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state       <= ST_SHIFT;
                        r_count       <= w_req_sat;
                        r_idx         <= '0;
                        r_ser_out     <= (w_req_sat != '0);
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        // FRAME_LEN is at least 2, so bit 0 is never the last.
                        r_frame_end   <= 1'b0;
                        r_err_sat     <= w_req_over;
                    end
                end

                ST_SHIFT: begin
                    if (w_last_bit) begin
                        r_state       <= ST_DONE;
                        r_ser_out     <= 1'b0;
                        r_ser_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                        r_frame_end   <= 1'b0;
                        r_par_out     <= w_therm;
                        r_par_valid   <= 1'b1;
                    end else begin
                        r_idx         <= w_idx_next;
                        r_ser_out     <= (w_idx_next < r_count);
                        r_frame_start <= 1'b0;
                        r_frame_end   <= (w_idx_next == c_last_idx);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign par_out     = r_par_out;
    assign par_valid   = r_par_valid;
    assign err_sat     = r_err_sat;

endmodule
`default_nettype wire
